// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the add/sub unit: field widths, exponent constants and the
// canonical quiet-NaN pattern.
package fpu_pkg;

  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_FRAC_W = 23;
  localparam int unsigned BIAS      = 127;
  localparam int unsigned EXP_MAX   = 255;
  localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic inexact;
  } fp_flags_t;

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even of a normalised {hidden,frac,G,R,S} mantissa, with carry
// renormalisation, overflow to Inf and flush of a zero exponent to signed zero.
module fpu_round_rne #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                    sign_i,
  input  logic [EXP_W:0]          exp_i,
  input  logic [FRAC_W+3:0]       mant_i,
  output logic [EXP_W+FRAC_W:0]   result_o,
  output logic                    overflow_o,
  output logic                    inexact_o
);

  localparam int unsigned MantW = FRAC_W + 1;
  localparam logic [EXP_W+1:0] ExpMax = {2'b00, {EXP_W{1'b1}}};

  logic               guard, rnd, sticky, lsb, round_up;
  logic [MantW:0]     sum;
  logic [EXP_W+1:0]   exp_r;
  logic [FRAC_W-1:0]  frac;

  always_comb begin
    guard    = mant_i[2];
    rnd      = mant_i[1];
    sticky   = mant_i[0];
    lsb      = mant_i[3];
    round_up = guard & (rnd | sticky | lsb);

    // One bit of headroom so an all-ones mantissa carries out instead of wrapping.
    sum   = {1'b0, mant_i[FRAC_W+3:3]} + {{MantW{1'b0}}, round_up};
    exp_r = {1'b0, exp_i} + {{(EXP_W+1){1'b0}}, sum[MantW]};
    frac  = sum[MantW] ? sum[FRAC_W:1] : sum[FRAC_W-1:0];

    result_o   = {sign_i, exp_r[EXP_W-1:0], frac};
    overflow_o = 1'b0;
    inexact_o  = guard | rnd | sticky;

    if (exp_r >= ExpMax) begin
      result_o   = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      overflow_o = 1'b1;
      inexact_o  = 1'b1;
    end else if (exp_r == '0) begin
      result_o  = {sign_i, {(EXP_W+FRAC_W){1'b0}}};
      inexact_o = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_result_pack.sv
// Final stage of the FP32 add/sub unit: merges exception-unit special cases with the rounded
// datapath result and presents it through a 2-stage valid/ready pipeline.
module fpu_result_pack
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W  = FP_EXP_W,
  parameter int unsigned FRAC_W = FP_FRAC_W,
  parameter logic [31:0] QNAN   = FP_QNAN
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_aos,
  input  logic        i_signA,
  input  logic        i_signB,
  input  logic [7:0]  i_expA,
  input  logic        i_spe_sig,
  input  logic        i_spe_m,
  input  logic        i_e_mt,
  input  logic        i_res_sign,
  input  logic [8:0]  i_res_exp,
  input  logic [26:0] i_res_mant,
  input  logic        i_res_zero,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_invalid,
  output logic        o_overflow,
  output logic        o_inexact
);

  logic [EXP_W+FRAC_W:0] rnd_result;
  logic                  rnd_overflow, rnd_inexact;
  logic                  inf_sign;

  fp32_t     s1_result_d, s1_result_q, s2_result_q;
  fp_flags_t s1_flags_d, s1_flags_q, s2_flags_q;
  logic      s1_valid_q, s2_valid_q;
  logic      s1_adv;

  fpu_round_rne #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_round (
    .sign_i     (i_res_sign),
    .exp_i      (i_res_exp),
    .mant_i     (i_res_mant),
    .result_o   (rnd_result),
    .overflow_o (rnd_overflow),
    .inexact_o  (rnd_inexact)
  );

  // Ready ripples combinationally from the output back through both stages.
  assign s1_adv  = ~s2_valid_q | i_ready;
  assign o_ready = ~s1_valid_q | s1_adv;

  // The Inf operand donates the sign; otherwise B is the Inf and SUB negates it.
  assign inf_sign = ((i_expA == 8'hFF) || i_e_mt) ? i_signA : (i_signB ^ ~i_aos);

  always_comb begin
    s1_result_d          = rnd_result;
    s1_flags_d.invalid   = 1'b0;
    s1_flags_d.overflow  = rnd_overflow;
    s1_flags_d.inexact   = rnd_inexact;
    if (i_spe_m) begin
      s1_result_d = QNAN;
      s1_flags_d  = '{invalid: 1'b1, overflow: 1'b0, inexact: 1'b0};
    end else if (i_spe_sig) begin
      s1_result_d = '{sign: inf_sign, exp: '1, frac: '0};
      s1_flags_d  = '0;
    end else if (i_res_zero) begin
      s1_result_d = '0;
      s1_flags_d  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_result_q <= '0;
      s1_flags_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
    end else begin
      if (o_ready) begin
        s1_valid_q <= i_valid;
        if (i_valid) begin
          s1_result_q <= s1_result_d;
          s1_flags_q  <= s1_flags_d;
        end
      end
      if (s1_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_result_q <= s1_result_q;
          s2_flags_q  <= s1_flags_q;
        end
      end
    end
  end

  assign o_valid    = s2_valid_q;
  assign o_result   = s2_result_q;
  assign o_invalid  = s2_flags_q.invalid;
  assign o_overflow = s2_flags_q.overflow;
  assign o_inexact  = s2_flags_q.inexact;

endmodule

// File: tb/tb_fpu_result_pack.sv
// Scoreboard bench for fpu_result_pack: directed vectors push expected results, a monitor
// pops and compares on each output transfer and checks stability while stalled.
module tb_fpu_result_pack;

  typedef struct packed {
    logic        aos;
    logic        signA;
    logic        signB;
    logic [7:0]  expA;
    logic        spe_sig;
    logic        spe_m;
    logic        e_mt;
    logic        res_sign;
    logic [8:0]  res_exp;
    logic [26:0] res_mant;
    logic        res_zero;
  } vec_t;

  // {result, invalid, overflow, inexact}
  typedef logic [34:0] exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_aos = 1'b0, i_signA = 1'b0, i_signB = 1'b0;
  logic [7:0]  i_expA = '0;
  logic        i_spe_sig = 1'b0, i_spe_m = 1'b0, i_e_mt = 1'b0;
  logic        i_res_sign = 1'b0;
  logic [8:0]  i_res_exp = '0;
  logic [26:0] i_res_mant = '0;
  logic        i_res_zero = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_result;
  logic        o_invalid, o_overflow, o_inexact;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic        have_hold = 1'b0;
  logic [34:0] hold_val;

  always #5 i_clk = ~i_clk;

  fpu_result_pack dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_aos      (i_aos),
    .i_signA    (i_signA),
    .i_signB    (i_signB),
    .i_expA     (i_expA),
    .i_spe_sig  (i_spe_sig),
    .i_spe_m    (i_spe_m),
    .i_e_mt     (i_e_mt),
    .i_res_sign (i_res_sign),
    .i_res_exp  (i_res_exp),
    .i_res_mant (i_res_mant),
    .i_res_zero (i_res_zero),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_invalid  (o_invalid),
    .o_overflow (o_overflow),
    .o_inexact  (o_inexact)
  );

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic vec_t normal(input logic s, input logic [8:0] e, input logic [26:0] m);
    vec_t v = '0;
    v.res_sign = s;
    v.res_exp  = e;
    v.res_mant = m;
    return v;
  endfunction

  // Present v from just after a rising edge; push expected on the edge that accepts it.
  task automatic send(input vec_t v, input exp_t e);
    int budget = 200;
    #1;
    {i_aos, i_signA, i_signB, i_expA, i_spe_sig, i_spe_m, i_e_mt,
     i_res_sign, i_res_exp, i_res_mant, i_res_zero} = v;
    i_valid = 1'b1;
    @(negedge i_clk);
    while (!o_ready && budget > 0) begin
      budget--;
      @(negedge i_clk);
    end
    if (!o_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: o_ready=%b want 1", o_ready);
    end else begin
      sb.push_back(e);
    end
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    #0;
  endtask

  // Monitor: compare on each output transfer, and hold-stability while stalled.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid) begin
      if (have_hold) check("stall_stable", {o_result, o_invalid, o_overflow, o_inexact}, hold_val);
      if (i_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h want none", o_result);
        end else begin
          check("result", {o_result, o_invalid, o_overflow, o_inexact}, sb.pop_front());
        end
      end
      have_hold <= !i_ready;
      hold_val  <= {o_result, o_invalid, o_overflow, o_inexact};
    end else begin
      have_hold <= 1'b0;
    end
  end

  task automatic drain();
    int budget = 100;
    while (sb.size() != 0 && budget > 0) begin
      budget--;
      @(posedge i_clk);
    end
    check("drain_empty", 35'(sb.size()), 35'd0);
  endtask

  initial begin
    vec_t v;
    #12;
    check("reset_outputs", {o_result, o_invalid, o_overflow, o_inexact}, 35'd0);
    check("reset_valid_ready", {33'd0, o_valid, o_ready}, 35'b01);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);

    send(normal(1'b0, 9'd127, 27'h4000000), {32'h3F80_0000, 3'b000});
    send(normal(1'b0, 9'd127, 27'h4000004), {32'h3F80_0000, 3'b001});
    send(normal(1'b0, 9'd127, 27'h400000C), {32'h3F80_0002, 3'b001});
    send(normal(1'b0, 9'd127, 27'h7FFFFFC), {32'h4000_0000, 3'b001});
    send(normal(1'b0, 9'd254, 27'h7FFFFFC), {32'h7F80_0000, 3'b011});
    send(normal(1'b1, 9'd0,   27'h4000000), {32'h8000_0000, 3'b001});
    send(normal(1'b1, 9'd130, 27'h4000003), {32'hC100_0000, 3'b001});

    v = '0; v.spe_m = 1'b1; v.spe_sig = 1'b1; v.expA = 8'hFF; v.res_sign = 1'b1;
    send(v, {32'h7FC0_0000, 3'b100});
    v = '0; v.spe_sig = 1'b1; v.expA = 8'hFF; v.signA = 1'b1; v.e_mt = 1'b1; v.aos = 1'b1;
    send(v, {32'hFF80_0000, 3'b000});
    v = '0; v.spe_sig = 1'b1; v.expA = 8'h00; v.signB = 1'b0; v.aos = 1'b0;
    send(v, {32'hFF80_0000, 3'b000});
    v = '0; v.spe_sig = 1'b1; v.expA = 8'h00; v.signB = 1'b1; v.aos = 1'b1; v.signA = 1'b0;
    send(v, {32'hFF80_0000, 3'b000});
    v = normal(1'b1, 9'd140, 27'h5555555); v.res_zero = 1'b1;
    send(v, {32'h0000_0000, 3'b000});
    drain();

    // Back-to-back stream with a 3-cycle downstream stall in the middle.
    fork
      begin
        send(normal(1'b0, 9'd127, 27'h4000000), {32'h3F80_0000, 3'b000});
        send(normal(1'b0, 9'd128, 27'h4000000), {32'h4000_0000, 3'b000});
        send(normal(1'b0, 9'd129, 27'h4000000), {32'h4080_0000, 3'b000});
        send(normal(1'b0, 9'd130, 27'h4000000), {32'h4100_0000, 3'b000});
        send(normal(1'b0, 9'd131, 27'h4000000), {32'h4180_0000, 3'b000});
      end
      begin
        repeat (3) @(posedge i_clk);
        #1 i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();

    // Fill both stages, then reset asynchronously mid-cycle.
    i_ready = 1'b0;
    send(normal(1'b0, 9'd127, 27'h4000000), {32'h3F80_0000, 3'b000});
    send(normal(1'b0, 9'd128, 27'h4000000), {32'h4000_0000, 3'b000});
    @(negedge i_clk);
    check("full_before_reset", {34'd0, o_valid}, 35'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("reset_drops_valid", {34'd0, o_valid}, 35'd0);
    check("reset_clears_result", {o_result, o_invalid, o_overflow, o_inexact}, 35'd0);
    sb.delete();
    @(negedge i_clk);
    i_ready = 1'b1;
    i_rst_n = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    check("no_stale_after_reset", {34'd0, o_valid}, 35'd0);

    send(normal(1'b0, 9'd129, 27'h6000000), {32'h40C0_0000, 3'b000});
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1);
  end

endmodule
